// File: rtl/axil_sdram_pkg.sv
// Shared definitions for the SDRAM-to-AXI4-Lite read path: response codes,
// FIFO word layout and the occupancy states of the read-data output buffer.
package axil_sdram_pkg;

  localparam int DATA_W_DEF = 32;
  // The error flag sits just above the data bits in each FIFO word.
  localparam int ERR_BIT = DATA_W_DEF;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/rdata_skid_buf.sv
// Two-entry register buffer holding FIFO words in arrival order; the head
// drives the R channel and is only replaced by a handshake.
module rdata_skid_buf
  import axil_sdram_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enq,
  input  logic         deq,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         valid,
  output logic [1:0]   occ
);

  occ_e         state;
  logic [W-1:0] tail;

  // NOTE: both slots are reset because the head feeds rdata directly and
  // must read as zero after reset; it is only two registers, not a RAM.
  // NOTE: all state here is sequential, so every update uses <= to avoid
  // ordering races between the registers inside this block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      valid <= 1'b0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        EMPTY: if (enq) begin
          head  <= din;
          state <= ONE;
          valid <= 1'b1;
        end
        ONE: begin
          if (enq && deq) begin
            head <= din;
          end else if (enq) begin
            tail  <= din;
            state <= TWO;
          end else if (deq) begin
            state <= EMPTY;
            valid <= 1'b0;
          end
        end
        TWO: if (deq) begin
          head <= tail;
          if (enq) tail  <= din;
          else     state <= ONE;
        end
        default: begin
          state <= EMPTY;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign occ = state;

  // The pop credit never lets a word land in a full buffer without a drain.
  assert property (@(posedge clk) disable iff (reset) !(state == TWO && enq && !deq));

endmodule

// File: rtl/axil_rdata_responder.sv
// Pops {error, data} words from the read-return FIFO and presents them on the
// AXI4-Lite R channel at up to one beat per cycle.
module axil_rdata_responder
  import axil_sdram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FIFO_W = DATA_W + 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [FIFO_W-1:0] fifo_data_out,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic [DATA_W-1:0] s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic [CNT_W-1:0]  beat_count,
  output logic              busy
);

  logic              inflight;
  logic              deq;
  logic [1:0]        occ;
  logic [2:0]        committed;
  logic [FIFO_W-1:0] head;

  assign deq       = s_axil_rvalid & s_axil_rready;
  assign committed = {1'b0, occ} + {2'b00, inflight};

  // A pop is allowed only if the word it returns next cycle has a free slot,
  // counting the beat leaving this cycle as already freed.
  assign fifo_rd_en = !reset && !fifo_empty && (committed < (3'd2 + {2'b00, deq}));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight   <= 1'b0;
      beat_count <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (deq) beat_count <= beat_count + 1'b1;
    end
  end

  rdata_skid_buf #(.W(FIFO_W)) u_buf (
    .clk   (clk),
    .reset (reset),
    .enq   (inflight),
    .deq   (deq),
    .din   (fifo_data_out),
    .head  (head),
    .valid (s_axil_rvalid),
    .occ   (occ)
  );

  assign s_axil_rdata = head[DATA_W-1:0];
  assign s_axil_rresp = resp_of(head[DATA_W]);
  assign busy         = (occ != 2'd0) | inflight;

endmodule

// File: tb/tb_axil_rdata_responder.sv
// Scoreboard bench: a queue-based FIFO model feeds the responder, expected
// R beats are queued on push and checked by an independent negedge monitor.
module tb_axil_rdata_responder;

  localparam int DATA_W = 32;
  localparam int FIFO_W = DATA_W + 1;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fifo_empty = 1'b1;
  logic              fifo_rd_en;
  logic [FIFO_W-1:0] fifo_data_out = '0;
  logic              s_axil_rvalid;
  logic              s_axil_rready = 1'b0;
  logic [DATA_W-1:0] s_axil_rdata;
  logic [1:0]        s_axil_rresp;
  logic [CNT_W-1:0]  beat_count;
  logic              busy;

  axil_rdata_responder #(.DATA_W(DATA_W), .FIFO_W(FIFO_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .s_axil_rvalid (s_axil_rvalid),
    .s_axil_rready (s_axil_rready),
    .s_axil_rdata  (s_axil_rdata),
    .s_axil_rresp  (s_axil_rresp),
    .beat_count    (beat_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an ideal FIFO with registered read data, plus expected beats.
  logic [FIFO_W-1:0] push_q[$];
  logic [FIFO_W-1:0] fifo_q[$];
  logic [33:0]       exp_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_q.delete();
      push_q.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en && fifo_q.size() > 0) fifo_data_out <= fifo_q.pop_front();
      while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  task automatic push_word(input logic err, input logic [DATA_W-1:0] data);
    push_q.push_back({err, data});
    exp_q.push_back({(err ? 2'b10 : 2'b00), data});
  endtask

  // Monitor: scoreboard compare, hold-under-stall, counter and pop rules.
  logic [CNT_W-1:0] model_beats = '0;
  logic             stall_prev = 1'b0;
  logic [33:0]      prev_beat = '0;
  int               pops_seen = 0;

  always @(negedge clk) begin
    logic [33:0] e;
    if (reset) begin
      model_beats = '0;
      stall_prev  = 1'b0;
      exp_q.delete();
    end else begin
      if (fifo_rd_en) begin
        pops_seen++;
        check("pop_while_empty", fifo_empty, 1'b0);
      end
      check("beat_count", beat_count, model_beats);
      if (stall_prev) begin
        check("hold_valid", s_axil_rvalid, 1'b1);
        check("hold_beat", {s_axil_rresp, s_axil_rdata}, prev_beat);
      end
      if (s_axil_rvalid && s_axil_rready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {s_axil_rresp, s_axil_rdata}, 34'h0);
          check("unexpected_beat_present", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("rdata", s_axil_rdata, e[31:0]);
          check("rresp", s_axil_rresp, e[33:32]);
        end
        model_beats = model_beats + 1'b1;
      end
      stall_prev = s_axil_rvalid && !s_axil_rready;
      prev_beat  = {s_axil_rresp, s_axil_rdata};
    end
  end

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic done = 1'b0;
    to_drive();
    s_axil_rready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && push_q.size() == 0 && fifo_empty) done = 1'b1;
    end
    check("drain_done", done, 1'b1);
  endtask

  task automatic wait_valid(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (s_axil_rvalid) seen = 1'b1;
    end
    check("valid_seen", seen, 1'b1);
  endtask

  // Starts at a drive point with an idle design and rready=1.
  task automatic latency_word(input logic err, input logic [DATA_W-1:0] data);
    push_word(err, data);
    @(posedge clk);
    @(negedge clk);
    check("lat_pop", fifo_rd_en, 1'b1);
    @(negedge clk);
    check("lat_no_valid_yet", s_axil_rvalid, 1'b0);
    check("lat_single_pop", fifo_rd_en, 1'b0);
    @(negedge clk);
    check("lat_valid", s_axil_rvalid, 1'b1);
    @(negedge clk);
    check("lat_valid_drop", s_axil_rvalid, 1'b0);
    check("lat_busy_idle", busy, 1'b0);
  endtask

  initial begin
    int p0;
    logic seen;

    #2;
    check("rst_rvalid", s_axil_rvalid, 1'b0);
    check("rst_rdata", s_axil_rdata, 32'h0);
    check("rst_rresp", s_axil_rresp, 2'b00);
    check("rst_beat_count", beat_count, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    repeat (2) to_drive();
    reset = 1'b0;
    to_drive();

    // Single word, then an error-flagged word.
    s_axil_rready = 1'b1;
    latency_word(1'b0, 32'hDEAD_BEEF);
    check("single_beat_count", beat_count, 4'd1);
    to_drive();
    latency_word(1'b1, 32'h0000_1234);

    // Streaming: eight words, no bubble after the first beat.
    to_drive();
    for (int i = 1; i <= 8; i++) push_word(1'b0, DATA_W'(i));
    wait_valid(seen);
    for (int i = 0; i < 8; i++) begin
      check("stream_valid", s_axil_rvalid, 1'b1);
      @(negedge clk);
    end
    check("stream_end", s_axil_rvalid, 1'b0);
    drain();

    // Back-pressure: only two pops while the sink stalls.
    to_drive();
    s_axil_rready = 1'b0;
    p0 = pops_seen;
    for (int i = 1; i <= 4; i++) push_word(1'b0, DATA_W'(i));
    repeat (10) @(negedge clk);
    check("bp_pops", pops_seen - p0, 2);
    check("bp_valid", s_axil_rvalid, 1'b1);
    check("bp_head", s_axil_rdata, 32'd1);
    drain();

    // Alternating ready over six words.
    to_drive();
    for (int i = 0; i < 6; i++) push_word(i[0], 32'h100 + DATA_W'(i));
    for (int i = 0; i < 30; i++) begin
      s_axil_rready = ~i[0];
      to_drive();
    end
    drain();

    // Reset with one word held and a second in flight.
    to_drive();
    s_axil_rready = 1'b0;
    push_word(1'b0, 32'h11);
    push_word(1'b0, 32'h22);
    repeat (3) to_drive();
    check("pre_rst_busy", busy, 1'b1);
    check("pre_rst_valid", s_axil_rvalid, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_rvalid", s_axil_rvalid, 1'b0);
    check("mid_rst_rd_en", fifo_rd_en, 1'b0);
    check("mid_rst_beat_count", beat_count, 4'h0);
    check("mid_rst_busy", busy, 1'b0);
    to_drive();
    to_drive();
    reset = 1'b0;
    s_axil_rready = 1'b1;
    to_drive();
    latency_word(1'b0, 32'hA5A5_A5A5);
    check("post_rst_count", beat_count, 4'd1);

    // Counter wrap: 16 more beats after the one above.
    to_drive();
    for (int i = 0; i < 16; i++) push_word(1'b0, 32'h200 + DATA_W'(i));
    drain();
    check("wrap_count", beat_count, 4'd1);

    // Randomised traffic and ready.
    for (int i = 0; i < 400; i++) begin
      s_axil_rready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) push_word(1'($urandom), $urandom);
      to_drive();
    end
    drain();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
